dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder for the MEM stage of the pipelined CPU. It accepts one load or store per instruction from the MEM stage and holds the pipeline with `stall_o` until a fixed-latency backing array completes the access. It then presents the load result on `rdata_o` for capture into the MEM/WB pipeline register. It is the target side of the MEM-stage memory interface.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; word address range is 0..DEPTH_WORDS-1.
- `LATENCY`, default 4: cycles from request acceptance to completion, ≥1.

- `clk_i`  in  1  single clock; everything is on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `MemRead_i`  in  1  MEM-stage load request.
- `MemWrite_i`  in  1  MEM-stage store request.
- `addr_i`  in  32  byte address; must be word-aligned.
- `wdata_i`  in  32  store data.
- `stall_o`  out  1  hold PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB.
- `rdata_o`  out  32  load data; feeds MEM/WB `MemOut`.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  sticky error flag: misaligned, out-of-range or conflicting request.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, with `req = MemRead_i | MemWrite_i`:
  - Latches address, data and operation.
  - Loads the counter with LATENCY-1.
  - Goes to BUSY, or directly to DONE if LATENCY=1.
- BUSY: decrements the counter each cycle. At count 0 it performs the access and goes to DONE.
- DONE: `done_o`=1. Request inputs are ignored because they are still the same held instruction. Unconditionally goes to IDLE.
- `stall_o` is combinational: `(IDLE & req) | BUSY`. It is never high in DONE, so the pipeline advances on the DONE edge.
- Access is performed at the edge entering DONE:
  - Store: writes `wdata_i` (latched copy) to the array.
  - Load: registers the word into `rdata_o`.
- `rdata_o` holds its value until the next load completes. Stores do not change it.
- Both MemRead_i and MemWrite_i high: treated as a store, and `err_o` is set.
- Misaligned (`addr[1:0]≠0`) or out-of-range (`addr[31:2]≥DEPTH_WORDS`):
  - Full latency and handshake still occur.
  - No array write takes place.
  - A load returns 0.
  - `err_o` is set.
- `err_o` stays set until reset.
- Address arithmetic: word index = `addr_i[31:2]`. There is no wrap-around; indices at or above DEPTH_WORDS are errors.

## Timing
- Reset values: state IDLE, counter 0, `rdata_o`=0, `done_o`=0, `err_o`=0. `stall_o` then follows the combinational inputs.
- Array contents are not reset.
- Request seen in IDLE at cycle t:
  - `stall_o` is high in cycles t..t+LATENCY-1, which is LATENCY cycles.
  - `done_o` and valid `rdata_o` appear in cycle t+LATENCY.
- Back-to-back memory instructions: the next request is accepted in the cycle after DONE, which is t+LATENCY+1.
- Reset mid-operation (BUSY or DONE): the transaction is aborted, no array write happens, and `rdata_o` and `err_o` are cleared. IDLE is re-entered the next cycle.
- No-request cycles in IDLE: no state change, `stall_o`=0.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` (IDLE, BUSY, DONE)
  - op enum (READ, WRITE)
  - width constants: `DATA_W`=32, `ADDR_W`=32.
- Sub-module `dmem_array`: single-port synchronous storage, DEPTH_WORDS×32, with write enable and registered read, instantiated once. The FSM, counter and error logic live in `dmem_responder`.

## Test plan
- Reset, then idle: `stall_o`=0, `rdata_o`=0, `err_o`=0, `done_o`=0 for 10 cycles.
- Store 0xDEADBEEF to 0x10 at cycle t, then load 0x10: stall for cycles t..t+3, `done_o` at t+4; second `done_o` at t+9 with `rdata_o`=0xDEADBEEF.
- Load from 0x3 (misaligned): full 4-cycle stall, `rdata_o`=0, `err_o`=1 and staying 1.
- Store to 0x1000 with DEPTH_WORDS=1024 (index 1024): `err_o`=1, and a later load of 0x0 still returns the previously written value.
- `rst_i` pulsed while in BUSY during a store of 0x12345678 to 0x20: a following load of 0x20 returns the old value, and the FSM is in IDLE one cycle after reset.
- LATENCY=1 build: a load at cycle t gives `stall_o` high only at t, `done_o` at t+1, and a new request is accepted at t+2.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_pkg: shared types and constants for the MEM-stage data-memory responder.
//   dmem_state_t : responder FSM state (IDLE, BUSY, DONE)
//   dmem_op_t    : latched operation (READ, WRITE)
//   DATA_W/ADDR_W: bus widths
//   addr_bad()   : misaligned or out-of-range byte address test
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } dmem_op_t;

    // True when the byte address cannot reach the array: not word-aligned,
    // or word index at/above the depth (no wrap-around).
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                      input int unsigned      depth_words);
        logic [ADDR_W-1:0] word_idx;
        word_idx = {2'b00, addr[ADDR_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage memory bus between the pipeline (master) and
// the data-memory responder (slave).
//   MemRead_i/MemWrite_i/addr_i/wdata_i : request, driven by the MEM stage
//   stall_o/rdata_o/done_o/err_o        : response, driven by the responder
// Signal names keep the responder-side _i/_o suffixes so they read the same
// at both ends of the link.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              MemRead_i;
    logic              MemWrite_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              stall_o;
    logic [DATA_W-1:0] rdata_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output MemRead_i, MemWrite_i, addr_i, wdata_i,
        input  stall_o, rdata_o, done_o, err_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, wdata_i,
        output stall_o, rdata_o, done_o, err_o
    );

endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port synchronous word storage, DEPTH_WORDS x DATA_W.
//   clk_i   : clock
//   we_i    : write enable, writes wdata_i to word idx_i
//   re_i    : read enable, registers word idx_i into rdata_o
//   idx_i   : word index (caller guarantees it is in range when enabled)
//   wdata_i : write data
//   rdata_o : registered read data, holds between reads
// Contents are intentionally not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store, stalls the pipeline for LATENCY cycles, then pulses
// done_o for one cycle with load data on rdata_o.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : MemRead_i, MemWrite_i, addr_i, wdata_i in;
//                  stall_o (combinational), rdata_o, done_o, err_o (sticky) out
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    dmem_state_t       state_q,    state_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    dmem_op_t          op_q,       op_d;
    logic              bad_q,      bad_d;
    logic              conflict_q, conflict_d;
    logic [AW-1:0]     idx_q,      idx_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic              rvalid_q,   rvalid_d;

    logic              req_s;
    logic              access_s;
    logic              we_s;
    logic              re_s;
    dmem_op_t          cur_op_s;
    logic              cur_bad_s;
    logic              cur_conflict_s;
    logic [AW-1:0]     cur_idx_s;
    logic [DATA_W-1:0] cur_wdata_s;
    logic [DATA_W-1:0] arr_rdata_s;

    assign req_s = bus.MemRead_i | bus.MemWrite_i;

    // Transaction attributes: live inputs while IDLE (needed for the
    // LATENCY=1 case, which completes on the accepting edge), latched copies
    // afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            cur_op_s       = bus.MemWrite_i ? WRITE : READ;
            cur_bad_s      = addr_bad(bus.addr_i, DEPTH_WORDS);
            cur_conflict_s = bus.MemRead_i & bus.MemWrite_i;
            cur_idx_s      = bus.addr_i[AW+1:2];
            cur_wdata_s    = bus.wdata_i;
        end else begin
            cur_op_s       = op_q;
            cur_bad_s      = bad_q;
            cur_conflict_s = conflict_q;
            cur_idx_s      = idx_q;
            cur_wdata_s    = wdata_q;
        end
    end

    // FSM, latency counter and completion bookkeeping.
    // The counter is loaded with LATENCY-1 on acceptance; the access happens
    // on the edge where it decrements to zero, so IDLE plus the BUSY cycles
    // give exactly LATENCY stall cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        bad_d      = bad_q;
        conflict_d = conflict_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        access_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    op_d       = cur_op_s;
                    bad_d      = cur_bad_s;
                    conflict_d = cur_conflict_s;
                    idx_d      = cur_idx_s;
                    wdata_d    = cur_wdata_s;
                    if (LATENCY == 1) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        access_s = 1'b1;
                    end else begin
                        state_d  = BUSY;
                        cnt_d    = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // <= guards against a corrupted zero count wrapping around.
                if (cnt_q <= CW'(1)) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    access_s = 1'b1;
                end else begin
                    cnt_d    = cnt_q - CW'(1);
                    state_d  = BUSY;
                end
            end
            DONE: begin
                // Inputs still show the same held instruction; ignore them.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Array enables and sticky status; reset suppresses any access.
    always_comb begin
        we_s     = 1'b0;
        re_s     = 1'b0;
        rvalid_d = rvalid_q;
        err_d    = err_q;
        done_d   = access_s;
        if (access_s && !rst_i) begin
            we_s  = (cur_op_s == WRITE) && !cur_bad_s;
            re_s  = (cur_op_s == READ)  && !cur_bad_s;
            err_d = err_q | cur_bad_s | cur_conflict_s;
            if (cur_op_s == READ) begin
                rvalid_d = !cur_bad_s;
            end else begin
                rvalid_d = rvalid_q;
            end
        end else begin
            we_s = 1'b0;
            re_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= READ;
            bad_q      <= 1'b0;
            conflict_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            bad_q      <= bad_d;
            conflict_q <= conflict_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (we_s),
        .re_i    (re_s),
        .idx_i   (cur_idx_s),
        .wdata_i (cur_wdata_s),
        .rdata_o (arr_rdata_s)
    );

    // The array read register only updates on good loads; rvalid_q masks it
    // to zero after reset and after an errored load.
    assign bus.rdata_o = rvalid_q ? arr_rdata_s : {DATA_W{1'b0}};
    assign bus.stall_o = ((state_q == IDLE) && req_s) || (state_q == BUSY);
    assign bus.done_o  = done_q;
    assign bus.err_o   = err_q;

endmodule
